mcpu_ctrl: RTL and testbench
============================

MCPU_CTRL -- requirements
Module: mcpu_ctrl

Interface
REQ-001 Parameter ICNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  1 = fetch new instructions; 0 = stop at the next S_IF.
REQ-005 inst_ack  input  1  instruction source: inst_code is valid this cycle.
REQ-006 inst_code  input  32  MIPS-format instruction word.
REQ-007 zf, of  input  1 each  ALU zero and overflow flags, valid in S_EX.
REQ-008 inst_req  output  1  instruction request to the source.
REQ-009 ir_write, pc_write, pc_branch  output  1 each  IR load, PC+4 update, PC branch/jump update.
REQ-010 reg_we, mem_we, mem_re  output  1 each  register-file write, data-memory write, data-memory read strobes.
REQ-011 alu_op  output  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 SLL.
REQ-012 alu_src_imm, imm_zext, wb_sel_mem  output  1 each  B operand is immediate; zero-extend (else sign-extend); write-back source is memory.
REQ-013 r_addr_a, r_addr_b, w_addr  output  5 each  register-file read and write addresses.
REQ-014 state  output  3  current FSM state, for debug display.
REQ-015 illegal, ovf_trap  output  1 each  sticky error flags.
REQ-016 icount  output  ICNT_W  count of retired instructions.

Function
REQ-017 States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_HALT=5; 6 and 7 go to S_IF on the next clock.
REQ-018 S_IF: with run=1 and no error flag set, inst_req=1; on inst_ack=1, ir_write=1, pc_write=1, go to S_ID; otherwise stay in S_IF.
REQ-019 S_ID: decode the latched IR; r_addr_a=rs, r_addr_b=rt; an unsupported opcode/funct sets illegal and goes to S_HALT; otherwise go to S_EX.
REQ-020 Supported R-type (opcode 0), funct to alu_op: 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x00 SLL (shamt is the operand); w_addr=rd.
REQ-021 Supported I-type, opcode to alu_op: 0x08 ADDI ADD (sign-extend), 0x0C ANDI, 0x0D ORI, 0x0E XORI (zero-extend), 0x23 LW ADD, 0x2B SW ADD, 0x04 BEQ SUB; 0x02 J; w_addr=rt.
REQ-022 S_EX: alu_op and alu_src_imm held stable for the whole state; BEQ asserts pc_branch=1 when zf=1 and retires; J asserts pc_branch=1 and retires; LW/SW go to S_MEM; all others go to S_WB.
REQ-023 ADD, SUB and ADDI with of=1 in S_EX set ovf_trap, suppress write-back and go to S_HALT; the instruction does not retire.
REQ-024 S_MEM: LW asserts mem_re=1 and goes to S_WB; SW asserts mem_we=1 and retires.
REQ-025 S_WB: reg_we=1 unless w_addr=0; wb_sel_mem=1 for LW only; retires.
REQ-026 Retire = one cycle with icount+1, wrapping modulo 2^ICNT_W, then S_IF.
REQ-027 All strobes are Moore outputs decoded from state and IR, and are 1 for exactly one cycle per instruction.
REQ-028 Cycle counts from accepted inst_ack to return to S_IF: BEQ/J 3, ALU 4, SW 4, LW 5.
REQ-029 run=0 mid-instruction does not abort it; the instruction completes and the FSM waits in S_IF.
REQ-030 S_HALT: all strobes 0; remains there until rst.

Reset
REQ-031 rst=1: state=S_IF, IR=0, icount=0, illegal=0, ovf_trap=0, all strobes 0, alu_op=000, all address outputs 0; takes effect immediately, and any in-flight instruction is discarded without a write.

Structure
REQ-032 Shared package mcpu_pkg holds the state encodings, the alu_op codes, and the opcode/funct constants.
REQ-033 The combinational decoder is the sub-module mcpu_decode (IR in; alu_op, immediate/write-back selects, w_addr, class, illegal out); the FSM and counters stay in mcpu_ctrl.

Verification
REQ-034 Reset, run=1, ADD $3,$1,$2 (0x00221820) acked -> IF,ID,EX,WB; alu_op=100, w_addr=3, reg_we for one cycle, icount=1.
REQ-035 LW $5,4($0) (0x8C050004) -> mem_re in S_MEM, then reg_we with wb_sel_mem=1, w_addr=5; 5 cycles total.
REQ-036 BEQ with zf=1 (0x10000003) -> pc_branch=1 in S_EX, reg_we never asserted, back in S_IF after 3 cycles.
REQ-037 ADDI with of=1 in S_EX -> ovf_trap=1, no reg_we, state=S_HALT, icount unchanged; rst clears all of these.
REQ-038 Opcode 0x3F -> illegal=1, state=S_HALT; with inst_ack low for 10 cycles in S_IF the FSM stays in S_IF with inst_req=1.
REQ-039 Start from icount=2^ICNT_W-1, retire one instruction -> icount=0; assert rst in S_EX -> S_IF immediately and no reg_we.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// ALU operation codes, instruction classes and opcode/funct constants.
package mcpu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  // Instruction class decides the path through EX/MEM/WB.
  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_LW  = 3'd1,
    CLS_SW  = 3'd2,
    CLS_BEQ = 3'd3,
    CLS_J   = 3'd4
  } inst_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Only the signed arithmetic ops (ADD, SUB, ADDI) trap on overflow; they are
  // exactly the ALU-class instructions whose operation is ADD or SUB.
  function automatic logic is_ovf_op(input inst_cls_t cls, input logic [2:0] op);
    return (cls == CLS_ALU) && ((op == ALU_ADD) || (op == ALU_SUB));
  endfunction

endpackage

// File: rtl/mcpu_if.sv
// Controller <-> datapath/instruction-source signal bundle.
// master = controller side, slave = datapath / instruction source side.
interface mcpu_if #(parameter int ICNT_W = 16);
  logic              run;
  logic              inst_ack;
  logic [31:0]       inst_code;
  logic              zf;
  logic              of;
  logic              inst_req;
  logic              ir_write;
  logic              pc_write;
  logic              pc_branch;
  logic              reg_we;
  logic              mem_we;
  logic              mem_re;
  logic [2:0]        alu_op;
  logic              alu_src_imm;
  logic              imm_zext;
  logic              wb_sel_mem;
  logic [4:0]        r_addr_a;
  logic [4:0]        r_addr_b;
  logic [4:0]        w_addr;
  logic [2:0]        state;
  logic              illegal;
  logic              ovf_trap;
  logic [ICNT_W-1:0] icount;

  modport master (
    input  run, inst_ack, inst_code, zf, of,
    output inst_req, ir_write, pc_write, pc_branch, reg_we, mem_we, mem_re,
           alu_op, alu_src_imm, imm_zext, wb_sel_mem, r_addr_a, r_addr_b,
           w_addr, state, illegal, ovf_trap, icount
  );

  modport slave (
    output run, inst_ack, inst_code, zf, of,
    input  inst_req, ir_write, pc_write, pc_branch, reg_we, mem_we, mem_re,
           alu_op, alu_src_imm, imm_zext, wb_sel_mem, r_addr_a, r_addr_b,
           w_addr, state, illegal, ovf_trap, icount
  );
endinterface

// File: rtl/mcpu_decode.sv
// Combinational instruction decoder: maps the latched IR to ALU operation,
// operand/write-back selects, destination register and instruction class.
module mcpu_decode
  import mcpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        imm_zext,
  output logic        wb_sel_mem,
  output logic [4:0]  w_addr,
  output inst_cls_t   cls,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  // rs feeds the register file directly; shamt/immediate go to the datapath.
  assign unused_bits = ^{ir[25:21], ir[10:6]};

  // Opcode/funct table lookup; anything not listed is flagged illegal.
  always_comb begin
    alu_op      = ALU_AND;
    alu_src_imm = 1'b0;
    imm_zext    = 1'b0;
    wb_sel_mem  = 1'b0;
    w_addr      = ir[15:11];
    cls         = CLS_ALU;
    illegal     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin alu_op = ALU_ADD; alu_src_imm = 1'b1; w_addr = ir[20:16]; end
      OP_ANDI: begin alu_op = ALU_AND; alu_src_imm = 1'b1; imm_zext = 1'b1; w_addr = ir[20:16]; end
      OP_ORI:  begin alu_op = ALU_OR;  alu_src_imm = 1'b1; imm_zext = 1'b1; w_addr = ir[20:16]; end
      OP_XORI: begin alu_op = ALU_XOR; alu_src_imm = 1'b1; imm_zext = 1'b1; w_addr = ir[20:16]; end
      OP_LW: begin
        alu_op = ALU_ADD; alu_src_imm = 1'b1; wb_sel_mem = 1'b1;
        w_addr = ir[20:16]; cls = CLS_LW;
      end
      OP_SW:   begin alu_op = ALU_ADD; alu_src_imm = 1'b1; w_addr = ir[20:16]; cls = CLS_SW; end
      OP_BEQ:  begin alu_op = ALU_SUB; w_addr = ir[20:16]; cls = CLS_BEQ; end
      OP_J:    cls = CLS_J;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle controller FSM: IF -> ID -> EX -> [MEM] -> [WB] -> IF, with
// sticky illegal/overflow traps into HALT and a retired-instruction counter.
module mcpu_ctrl
  import mcpu_pkg::*;
#(
  parameter int ICNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  mcpu_if.master   bus
);

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic              illegal_q, illegal_d;
  logic              ovf_q, ovf_d;

  logic [2:0]        dec_alu_op;
  logic              dec_src_imm, dec_zext, dec_wb_mem, dec_illegal;
  logic [4:0]        dec_w_addr;
  inst_cls_t         dec_cls;

  logic inst_req_c, ir_write_c, pc_write_c, pc_branch_c;
  logic reg_we_c, mem_we_c, mem_re_c, retire_c, in_op;

  mcpu_decode u_decode (
    .ir          (ir_q),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm),
    .imm_zext    (dec_zext),
    .wb_sel_mem  (dec_wb_mem),
    .w_addr      (dec_w_addr),
    .cls         (dec_cls),
    .illegal     (dec_illegal)
  );

  // Next-state, strobe and counter logic; strobes depend on state and IR only,
  // plus the handshake/flag inputs that qualify them in IF and EX.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    icount_d    = icount_q;
    illegal_d   = illegal_q;
    ovf_d       = ovf_q;
    inst_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_branch_c = 1'b0;
    reg_we_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    retire_c    = 1'b0;
    case (state_q)
      S_IF: begin
        if (bus.run && !illegal_q && !ovf_q) begin
          inst_req_c = 1'b1;
          if (bus.inst_ack) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            ir_d       = bus.inst_code;
            state_d    = S_ID;
          end
        end
      end
      S_ID: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (dec_cls)
          CLS_BEQ: begin pc_branch_c = bus.zf; retire_c = 1'b1; end
          CLS_J:   begin pc_branch_c = 1'b1;   retire_c = 1'b1; end
          CLS_LW, CLS_SW: state_d = S_MEM;
          default: begin
            if (is_ovf_op(dec_cls, dec_alu_op) && bus.of) begin
              ovf_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              state_d = S_WB;
            end
          end
        endcase
      end
      S_MEM: begin
        if (dec_cls == CLS_LW) begin
          mem_re_c = 1'b1;
          state_d  = S_WB;
        end else begin
          mem_we_c = 1'b1;
          retire_c = 1'b1;
        end
      end
      S_WB: begin
        reg_we_c = (dec_w_addr != 5'd0);
        retire_c = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    if (retire_c) begin
      icount_d = icount_q + ICNT_W'(1);
      state_d  = S_IF;
    end
  end

  // State registers; reset discards any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      ir_q      <= '0;
      icount_q  <= '0;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      icount_q  <= icount_d;
      illegal_q <= illegal_d;
      ovf_q     <= ovf_d;
    end
  end

  // Decoded controls are only presented while an instruction is in flight.
  assign in_op = (state_q == S_ID) || (state_q == S_EX) ||
                 (state_q == S_MEM) || (state_q == S_WB);

  // Strobes are forced low while reset is held so nothing leaks mid-reset.
  assign bus.inst_req    = inst_req_c  & ~rst;
  assign bus.ir_write    = ir_write_c  & ~rst;
  assign bus.pc_write    = pc_write_c  & ~rst;
  assign bus.pc_branch   = pc_branch_c & ~rst;
  assign bus.reg_we      = reg_we_c    & ~rst;
  assign bus.mem_we      = mem_we_c    & ~rst;
  assign bus.mem_re      = mem_re_c    & ~rst;
  assign bus.alu_op      = in_op ? dec_alu_op : ALU_AND;
  assign bus.alu_src_imm = in_op & dec_src_imm;
  assign bus.imm_zext    = in_op & dec_zext;
  assign bus.wb_sel_mem  = (state_q == S_WB) & dec_wb_mem;
  assign bus.r_addr_a    = ir_q[25:21];
  assign bus.r_addr_b    = ir_q[20:16];
  assign bus.w_addr      = dec_w_addr;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.ovf_trap    = ovf_q;
  assign bus.icount      = icount_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: a per-instruction schedule model builds
// the expected cycle-by-cycle outputs, a negedge process compares them.
module tb_mcpu_ctrl;

  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcpu_if #(.ICNT_W(IW)) bus ();
  mcpu_ctrl #(.ICNT_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [2:0]    st;
    logic          inst_req, ir_write, pc_write, pc_branch, reg_we, mem_we, mem_re;
    logic          chk_alu;
    logic [2:0]    alu_op;
    logic          chk_src, src, zx;
    logic          chk_wb, wb_sel;
    logic [4:0]    w_addr;
    logic [IW-1:0] icount;
    logic          illegal, ovf, chk_addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   m_icount = 0;
  bit   m_illegal = 0, m_ovf = 0, in_rst = 1;
  int   reg_we_cnt = 0, mem_re_cnt = 0, mem_we_cnt = 0, br_cnt = 0;
  logic [4:0] last_w_addr = '0;
  logic       last_wb_sel = 1'b0;
  logic [2:0] last_ex_alu = '0;
  int   lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.icount = m_icount[IW-1:0];
    e.illegal = m_illegal;
    e.ovf = m_ovf;
    return e;
  endfunction

  // Instruction table: kind 0 ALU, 1 LW, 2 SW, 3 BEQ, 4 J.
  task automatic ref_decode(input logic [31:0] c, output bit ok, output int kind,
                            output logic [2:0] op, output bit src, output bit zx,
                            output logic [4:0] wreg, output bit ovfop);
    logic [5:0] opc, fn;
    opc = c[31:26]; fn = c[5:0];
    ok = 1; kind = 0; op = 3'd0; src = 0; zx = 0; wreg = c[15:11]; ovfop = 0;
    case (opc)
      6'h00: case (fn)
        6'h24: op = 3'd0;
        6'h25: op = 3'd1;
        6'h26: op = 3'd2;
        6'h27: op = 3'd3;
        6'h20: begin op = 3'd4; ovfop = 1; end
        6'h22: begin op = 3'd5; ovfop = 1; end
        6'h2A: op = 3'd6;
        6'h00: op = 3'd7;
        default: ok = 0;
      endcase
      6'h08: begin op = 3'd4; src = 1; wreg = c[20:16]; ovfop = 1; end
      6'h0C: begin op = 3'd0; src = 1; zx = 1; wreg = c[20:16]; end
      6'h0D: begin op = 3'd1; src = 1; zx = 1; wreg = c[20:16]; end
      6'h0E: begin op = 3'd2; src = 1; zx = 1; wreg = c[20:16]; end
      6'h23: begin kind = 1; op = 3'd4; src = 1; wreg = c[20:16]; end
      6'h2B: begin kind = 2; op = 3'd4; src = 1; wreg = c[20:16]; end
      6'h04: begin kind = 3; op = 3'd5; end
      6'h02: kind = 4;
      default: ok = 0;
    endcase
  endtask

  task automatic retire();
    m_icount = (m_icount + 1) % (1 << IW);
  endtask

  // Push the whole expected schedule of one accepted instruction.
  task automatic model_accept(input logic [31:0] c, input logic z, input logic o);
    exp_t e; bit ok, src, zx, ovfop; int kind; logic [2:0] op; logic [4:0] wreg;
    ref_decode(c, ok, kind, op, src, zx, wreg, ovfop);
    e = blank(3'd0); e.inst_req = 1; e.ir_write = 1; e.pc_write = 1; exp_q.push_back(e);
    e = blank(3'd1); exp_q.push_back(e);
    if (!ok) begin m_illegal = 1; return; end
    e = blank(3'd2); e.chk_alu = 1; e.alu_op = op;
    e.chk_src = (kind != 4); e.src = src; e.zx = zx;
    e.pc_branch = (kind == 3) ? z : (kind == 4);
    exp_q.push_back(e);
    if (kind >= 3) begin retire(); return; end
    if (kind == 0 && ovfop && o) begin m_ovf = 1; return; end
    if (kind == 1 || kind == 2) begin
      e = blank(3'd3); e.mem_re = (kind == 1); e.mem_we = (kind == 2); exp_q.push_back(e);
      if (kind == 2) begin retire(); return; end
    end
    e = blank(3'd4); e.reg_we = (wreg != 5'd0); e.chk_wb = 1;
    e.wb_sel = (kind == 1); e.w_addr = wreg; exp_q.push_back(e);
    retire();
  endtask

  // Every-cycle comparison against the model schedule.
  always @(negedge clk) begin
    exp_t e;
    if (in_rst) begin
      e = '0; e.chk_addr = 1;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else if (m_illegal || m_ovf) begin
      e = blank(3'd5);
    end else begin
      e = blank(3'd0); e.inst_req = bus.run;
    end
    chk("state", bus.state, e.st);
    chk("inst_req", bus.inst_req, e.inst_req);
    chk("ir_write", bus.ir_write, e.ir_write);
    chk("pc_write", bus.pc_write, e.pc_write);
    chk("pc_branch", bus.pc_branch, e.pc_branch);
    chk("reg_we", bus.reg_we, e.reg_we);
    chk("mem_we", bus.mem_we, e.mem_we);
    chk("mem_re", bus.mem_re, e.mem_re);
    chk("icount", bus.icount, e.icount);
    chk("illegal", bus.illegal, e.illegal);
    chk("ovf_trap", bus.ovf_trap, e.ovf);
    if (e.chk_alu) chk("alu_op", bus.alu_op, e.alu_op);
    if (e.chk_src) begin
      chk("alu_src_imm", bus.alu_src_imm, e.src);
      chk("imm_zext", bus.imm_zext, e.zx);
    end
    if (e.chk_wb) begin
      chk("wb_sel_mem", bus.wb_sel_mem, e.wb_sel);
      chk("w_addr", bus.w_addr, e.w_addr);
    end
    if (e.chk_addr) begin
      chk("rst_alu_op", bus.alu_op, 0);
      chk("rst_r_addr_a", bus.r_addr_a, 0);
      chk("rst_r_addr_b", bus.r_addr_b, 0);
      chk("rst_w_addr", bus.w_addr, 0);
    end
    if (bus.reg_we === 1'b1) begin
      reg_we_cnt++; last_w_addr = bus.w_addr; last_wb_sel = bus.wb_sel_mem;
    end
    if (bus.mem_re === 1'b1) mem_re_cnt++;
    if (bus.mem_we === 1'b1) mem_we_cnt++;
    if (bus.pc_branch === 1'b1) br_cnt++;
    if (bus.state === 3'd2) last_ex_alu = bus.alu_op;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Accept one instruction now and run until its schedule is consumed;
  // run/inst_ack/inst_code are scrambled while it is in flight.
  task automatic issue(input logic [31:0] c, input logic z, input logic o, output int n);
    bus.run = 1; bus.inst_ack = 1; bus.inst_code = c; bus.zf = z; bus.of = o;
    model_accept(c, z, o);
    n = 0;
    do begin
      step(); n++;
      if (exp_q.size() != 0) begin
        bus.run = 1'($urandom_range(0, 1));
        bus.inst_ack = 1'($urandom_range(0, 1));
        bus.inst_code = $urandom;
      end
    end while (exp_q.size() != 0 && n < 12);
    bus.inst_ack = 0; bus.run = 1;
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL issue_timeout actual=%0d required=<12 cycles", n);
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n, input bit force_run);
    repeat (n) begin
      bus.run = force_run ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.inst_ack = bus.run ? 1'b0 : 1'($urandom_range(0, 1));
      bus.inst_code = $urandom;
      step();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1; in_rst = 1; exp_q.delete();
    m_icount = 0; m_illegal = 0; m_ovf = 0; bus.inst_ack = 0;
    #1;
    chk("rst_state_now", bus.state, 0);
    chk("rst_reg_we_now", bus.reg_we, 0);
    repeat (n) step();
    rst = 0; in_rst = 0;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] c;
    logic [5:0] fn_t [8];
    logic [5:0] op_t [8];
    int sel;
    fn_t = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2A, 6'h00};
    op_t = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h02};
    sel = $urandom_range(0, 19);
    c = $urandom;
    if (sel < 8) begin
      c[31:26] = 6'h00; c[5:0] = fn_t[$urandom_range(0, 7)];
      if (sel == 0) c[15:11] = 5'd0;
    end else if (sel < 18) begin
      c[31:26] = op_t[$urandom_range(0, 7)];
      if (sel == 8) c[20:16] = 5'd0;
    end else if (sel == 18) begin
      c[31:26] = 6'h3F;
    end else begin
      c[31:26] = 6'h00; c[5:0] = 6'h01;
    end
    return c;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    bus.run = 0; bus.inst_ack = 0; bus.inst_code = 0; bus.zf = 0; bus.of = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_icount", bus.icount, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    rst = 0; in_rst = 0;

    // ADD $3,$1,$2
    issue(32'h00221820, 1'b0, 1'b0, lat);
    chk("add_lat", lat, 4); chk("add_back_if", bus.state, 0);
    chk("add_icount", bus.icount, 1); chk("add_reg_we_pulses", reg_we_cnt, 1);
    chk("add_w_addr", last_w_addr, 3); chk("add_alu_op", last_ex_alu, 3'b100);

    // LW $5,4($0)
    issue(32'h8C050004, 1'b0, 1'b0, lat);
    chk("lw_lat", lat, 5); chk("lw_back_if", bus.state, 0);
    chk("lw_mem_re_pulses", mem_re_cnt, 1); chk("lw_reg_we_pulses", reg_we_cnt, 2);
    chk("lw_w_addr", last_w_addr, 5); chk("lw_wb_sel_mem", last_wb_sel, 1);
    chk("lw_icount", bus.icount, 2);

    // BEQ taken
    issue(32'h10000003, 1'b1, 1'b0, lat);
    chk("beq_lat", lat, 3); chk("beq_back_if", bus.state, 0);
    chk("beq_reg_we_pulses", reg_we_cnt, 2); chk("beq_branch_pulses", br_cnt, 1);
    chk("beq_icount", bus.icount, 3);

    // ADDI overflow trap
    issue(32'h20220005, 1'b0, 1'b1, lat);
    chk("addi_ovf_state", bus.state, 5); chk("addi_ovf_flag", bus.ovf_trap, 1);
    chk("addi_ovf_icount", bus.icount, 3); chk("addi_ovf_reg_we", reg_we_cnt, 2);
    idle(3, 1);
    do_reset(2);
    chk("ovf_cleared", bus.ovf_trap, 0); chk("ovf_icount_cleared", bus.icount, 0);
    chk("ovf_state_if", bus.state, 0);

    // Illegal opcode 0x3F
    issue(32'hFC000000, 1'b0, 1'b0, lat);
    chk("ill_flag", bus.illegal, 1); chk("ill_state", bus.state, 5);
    idle(2, 1);
    do_reset(1);

    // Ten cycles without ack
    idle(10, 1);
    chk("wait_state_if", bus.state, 0); chk("wait_inst_req", bus.inst_req, 1);

    // icount wrap at 2^IW
    for (int i = 0; i < 15; i++) issue(32'h10000003, 1'($urandom_range(0, 1)), 1'b0, lat);
    chk("wrap_full", bus.icount, 15);
    issue(32'h08000000, 1'b0, 1'b0, lat);
    chk("wrap_zero", bus.icount, 0); chk("j_lat", lat, 3);

    // Reset during EX discards the instruction
    snap = reg_we_cnt;
    bus.run = 1; bus.inst_ack = 1; bus.inst_code = 32'h00221820;
    model_accept(32'h00221820, 1'b0, 1'b0);
    step();
    bus.inst_ack = 0;
    step();
    chk("ex_before_rst", bus.state, 2);
    do_reset(1);
    idle(3, 1);
    chk("ex_rst_no_reg_we", reg_we_cnt, snap); chk("ex_rst_icount", bus.icount, 0);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2), 0);
      issue(rnd_inst(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), lat);
      if (m_illegal || m_ovf) begin
        idle(2, 0);
        do_reset(1);
      end
    end
    idle(2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
